cic_comp_fir: RTL and testbench

- Decimated-rate FIR compensation stage placed directly downstream of cic_dec.
- Consumes the 16-bit truncated CIC output (dout_cut/dval) and corrects the CIC sinc^N passband droop.
- Optionally decimates by a further 2.
- Uses one time-multiplexed multiplier-accumulator, since input samples arrive at most once per R=64 clocks.

---
 rtl/cic_comp_fir_if.sv | 25 ++
 rtl/cic_comp_fir.sv | 163 ++++++++++++++++
 tb/tb_cic_comp_fir.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cic_comp_fir_if.sv
// Sample stream bundle between the CIC decimator and the compensation FIR.
// The FIR is the slave: it takes clr/din/din_vld and returns the filtered stream and status.
interface cic_comp_fir_if #(
  parameter int BIN  = 16,
  parameter int BOUT = 16
);
  logic                   clr;
  logic signed [BIN-1:0]  din;
  logic                   din_vld;
  logic signed [BOUT-1:0] dout;
  logic                   dout_vld;
  logic                   busy;
  logic                   sat;
  logic                   ovf;

  modport master (
    output clr, din, din_vld,
    input  dout, dout_vld, busy, sat, ovf
  );

  modport slave (
    input  clr, din, din_vld,
    output dout, dout_vld, busy, sat, ovf
  );
endinterface

// File: rtl/cic_comp_fir.sv
// CIC droop-compensation FIR with one time-multiplexed MAC and optional decimate-by-2.
// Result is retimed one clock after OUT, so dout_vld lands NTAP+2 clocks after the accepting edge.
module cic_comp_fir #(
  parameter int BIN  = 16,
  parameter int BOUT = 16,
  parameter int CW   = 16,
  parameter int NTAP = 16,
  parameter int DEC  = 1,
  parameter logic [NTAP*CW-1:0] COEF = {{((NTAP-1)*CW){1'b0}}, CW'(32767)}
) (
  input logic           clk,
  input logic           rst_n,
  cic_comp_fir_if.slave bus
);
  localparam int KW = (NTAP > 1) ? $clog2(NTAP) : 1;
  localparam int PW = BIN + CW;
  localparam int AW = BIN + CW + $clog2(NTAP);
  localparam logic signed [AW-1:0] HALF = AW'(1) <<< (CW - 2);
  localparam logic signed [AW-1:0] YMAX = AW'((longint'(1) <<< (BOUT - 1)) - 1);
  localparam logic signed [AW-1:0] YMIN = ~YMAX;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                 state_q, state_d;
  logic signed [BIN-1:0]  x_q [NTAP];
  logic signed [BIN-1:0]  x_d [NTAP];
  logic signed [CW-1:0]   coef [NTAP];
  logic [KW-1:0]          k_q, k_d;
  logic signed [AW-1:0]   acc_q, acc_d;
  logic                   phase_q, phase_d;
  logic                   ovf_q, ovf_d;
  logic                   pend_q, pend_d;
  logic signed [BOUT-1:0] res_q, res_d;
  logic                   res_sat_q, res_sat_d;
  logic signed [BOUT-1:0] dout_q;
  logic                   dout_vld_q;
  logic                   sat_q;
  logic                   shift_en;
  logic                   line_clr;
  logic signed [BIN-1:0]  x_sel;
  logic signed [CW-1:0]   c_sel;
  logic signed [PW-1:0]   prod;
  logic signed [AW-1:0]   y_full;

  genvar gi;
  generate
    for (gi = 0; gi < NTAP; gi++) begin : g_tap
      assign coef[gi] = COEF[gi*CW +: CW];
      if (gi == 0) begin : g_head
        assign x_d[gi] = line_clr ? '0 : (shift_en ? bus.din : x_q[gi]);
      end else begin : g_body
        assign x_d[gi] = line_clr ? '0 : (shift_en ? x_q[gi-1] : x_q[gi]);
      end
    end
  endgenerate

  assign x_sel  = x_q[k_q];
  assign c_sel  = coef[k_q];
  assign prod   = PW'(x_sel) * PW'(c_sel);
  // Round half up, then arithmetic shift back to sample scale.
  assign y_full = (acc_q + HALF) >>> (CW - 1);

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    acc_d     = acc_q;
    phase_d   = phase_q;
    ovf_d     = ovf_q;
    pend_d    = 1'b0;
    res_d     = res_q;
    res_sat_d = res_sat_q;
    shift_en  = 1'b0;
    line_clr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.clr) begin
          line_clr = 1'b1;
          phase_d  = 1'b0;
          ovf_d    = 1'b0;
        end else if (bus.din_vld) begin
          shift_en = 1'b1;
          phase_d  = (DEC == 2) ? ~phase_q : 1'b0;
          if (DEC == 1 || phase_q) begin
            state_d = MAC;
            k_d     = '0;
            acc_d   = '0;
          end
        end
      end
      MAC: begin
        if (bus.clr) begin
          state_d = IDLE;
        end else begin
          ovf_d = ovf_q | bus.din_vld;
          acc_d = acc_q + AW'(prod);
          k_d   = k_q + 1'b1;
          if (k_q == KW'(NTAP - 1)) state_d = OUT;
        end
      end
      OUT: begin
        state_d = IDLE;
        if (!bus.clr) begin
          ovf_d  = ovf_q | bus.din_vld;
          pend_d = 1'b1;
          if (y_full > YMAX) begin
            res_d     = {1'b0, {(BOUT-1){1'b1}}};
            res_sat_d = 1'b1;
          end else if (y_full < YMIN) begin
            res_d     = {1'b1, {(BOUT-1){1'b0}}};
            res_sat_d = 1'b1;
          end else begin
            res_d     = y_full[BOUT-1:0];
            res_sat_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      k_q       <= '0;
      acc_q     <= '0;
      phase_q   <= 1'b0;
      ovf_q     <= 1'b0;
      pend_q    <= 1'b0;
      res_q     <= '0;
      res_sat_q <= 1'b0;
      for (int i = 0; i < NTAP; i++) x_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      acc_q     <= acc_d;
      phase_q   <= phase_d;
      ovf_q     <= ovf_d;
      pend_q    <= pend_d;
      res_q     <= res_d;
      res_sat_q <= res_sat_d;
      x_q       <= x_d;
    end
  end

  // Output stage: dout holds between strobes, sat only qualifies a strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      dout_vld_q <= pend_q;
      sat_q      <= pend_q & res_sat_q;
      if (pend_q) dout_q <= res_q;
    end
  end

  assign bus.dout     = dout_q;
  assign bus.dout_vld = dout_vld_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.sat      = sat_q;
  assign bus.ovf      = ovf_q;
endmodule

// File: tb/tb_cic_comp_fir.sv
// Bench for cic_comp_fir: four instances (impulse, ramp, flat gain-4, decimate-by-2) share one
// input stream and are checked every cycle against an arithmetic reference model.
module tb_cic_comp_fir;
  localparam int ND  = 4;
  localparam int NT  = 16;
  localparam int LAT = NT + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic din_vld = 1'b0;
  logic signed [15:0] din = '0;

  always #5 clk = ~clk;

  function automatic logic [255:0] ramp_coef(input int step_sz);
    logic [255:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) r[k*16 +: 16] = 16'(step_sz * (k + 1));
    return r;
  endfunction

  localparam logic [255:0] COEF_IMP  = {240'd0, 16'd32767};
  localparam logic [255:0] COEF_RAMP = ramp_coef(1024);
  localparam logic [255:0] COEF_FLAT = {16{16'd8192}};

  cic_comp_fir_if #(.BIN(16), .BOUT(16)) bus [ND] ();

  logic signed [15:0] o_dout [ND];
  logic o_vld [ND];
  logic o_busy [ND];
  logic o_sat [ND];
  logic o_ovf [ND];

  genvar gi;
  generate
    for (gi = 0; gi < ND; gi++) begin : g_dut
      localparam logic [255:0] C = (gi == 1) ? COEF_RAMP : (gi == 2) ? COEF_FLAT : COEF_IMP;
      assign bus[gi].clr     = clr;
      assign bus[gi].din     = din;
      assign bus[gi].din_vld = din_vld;
      assign o_dout[gi] = bus[gi].dout;
      assign o_vld[gi]  = bus[gi].dout_vld;
      assign o_busy[gi] = bus[gi].busy;
      assign o_sat[gi]  = bus[gi].sat;
      assign o_ovf[gi]  = bus[gi].ovf;
      cic_comp_fir #(
        .BIN(16), .BOUT(16), .CW(16), .NTAP(NT),
        .DEC((gi == 3) ? 2 : 1), .COEF(C)
      ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus[gi])
      );
    end
  endgenerate

  // ---------------- reference model ----------------
  typedef struct {int d; int v; bit s;} ev_t;

  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  coef_m [ND][NT];
  int  dec_m [ND];
  int  hist [ND][NT];
  int  phase [ND];
  bit  ovf_m [ND];
  int  start [ND];
  int  out_edge [ND];
  int  out_val [ND];
  bit  out_sat [ND];
  int  e_dout [ND];
  bit  e_vld [ND];
  bit  e_sat [ND];
  bit  e_busy [ND];
  ev_t emit_q [$];

  task automatic chk(input string nm, input int d, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s dut%0d got=%0d exp=%0d (cyc %0d)", nm, d, got, exp, cyc);
    end
  endtask

  task automatic fir(input int d, output int y, output bit s);
    longint acc;
    longint q;
    acc = 0;
    for (int k = 0; k < NT; k++) acc += longint'(hist[d][k]) * longint'(coef_m[d][k]);
    q = (acc + 64'sd16384) >>> 15;
    s = 1'b0;
    if (q > 32767) begin
      q = 32767; s = 1'b1;
    end else if (q < -32768) begin
      q = -32768; s = 1'b1;
    end
    y = int'(q);
  endtask

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      for (int k = 0; k < NT; k++) hist[d][k] = 0;
      phase[d] = 0; ovf_m[d] = 1'b0; start[d] = -1000; out_edge[d] = -1;
      e_dout[d] = 0; e_vld[d] = 1'b0; e_sat[d] = 1'b0; e_busy[d] = 1'b0;
    end
  endtask

  // One clock edge: an accepted sample owns the MAC for edges start+1..start+NT+1.
  task automatic model_edge(input bit c, input bit v, input int x);
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int d = 0; d < ND; d++) begin
      bit busy_in;
      ev_t ev;
      e_vld[d] = (out_edge[d] == cyc);
      e_sat[d] = e_vld[d] && out_sat[d];
      if (e_vld[d]) begin
        e_dout[d] = out_val[d];
        ev.d = d; ev.v = out_val[d]; ev.s = out_sat[d];
        emit_q.push_back(ev);
      end
      busy_in = (cyc > start[d]) && (cyc <= start[d] + NT + 1);
      if (c) begin
        if (busy_in) begin
          start[d] = -1000; out_edge[d] = -1;
        end else begin
          for (int k = 0; k < NT; k++) hist[d][k] = 0;
          phase[d] = 0; ovf_m[d] = 1'b0;
        end
      end else if (v) begin
        if (busy_in) begin
          ovf_m[d] = 1'b1;
        end else begin
          for (int k = NT - 1; k > 0; k--) hist[d][k] = hist[d][k-1];
          hist[d][0] = x;
          phase[d] = (phase[d] + 1) % dec_m[d];
          if (phase[d] == 0) begin
            start[d] = cyc; out_edge[d] = cyc + LAT;
            fir(d, out_val[d], out_sat[d]);
          end
        end
      end
      e_busy[d] = (cyc >= start[d]) && (cyc <= start[d] + NT);
    end
  endtask

  task automatic check_outputs();
    for (int d = 0; d < ND; d++) begin
      if (o_vld[d] === 1'b1)
        $display("cyc=%0d dut%0d dout=%0d sat=%0d ovf=%0d", cyc, d, o_dout[d], o_sat[d], o_ovf[d]);
      chk("dout", d, longint'(o_dout[d]), e_dout[d]);
      chk("dout_vld", d, longint'(o_vld[d]), longint'(e_vld[d]));
      chk("busy", d, longint'(o_busy[d]), longint'(e_busy[d]));
      chk("sat", d, longint'(o_sat[d]), longint'(e_sat[d]));
      chk("ovf", d, longint'(o_ovf[d]), longint'(ovf_m[d]));
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step(input bit c, input bit v, input int x);
    clr = c; din_vld = v; din = 16'(x);
    @(posedge clk);
    #1;
    cyc++;
    model_edge(c, v, x);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, int'($urandom_range(0, 65535)) - 32768);
  endtask

  task automatic send(input int x, input int gap);
    step(1'b0, 1'b1, x);
    idle(gap - 1);
  endtask

  task automatic section_start();
    step(1'b1, 1'b0, 0);
    idle(2);
    emit_q.delete();
  endtask

  // Literal expectations on what the model emitted for one instance.
  task automatic pin_seq(input string nm, input int d, input int exp[$], input bit exp_s);
    int got[$];
    bit gs[$];
    foreach (emit_q[i]) if (emit_q[i].d == d) begin
      got.push_back(emit_q[i].v); gs.push_back(emit_q[i].s);
    end
    chk({nm, "_count"}, d, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      chk(nm, d, got[i], exp[i]);
      chk({nm, "_sat"}, d, longint'(gs[i]), longint'(exp_s));
    end
  endtask

  task automatic pin_last(input string nm, input int d, input int exp_v, input bit exp_s);
    int lv;
    bit ls;
    bit seen;
    lv = 0; ls = 1'b0; seen = 1'b0;
    foreach (emit_q[i]) if (emit_q[i].d == d) begin
      lv = emit_q[i].v; ls = emit_q[i].s; seen = 1'b1;
    end
    chk({nm, "_seen"}, d, longint'(seen), 1);
    chk(nm, d, lv, exp_v);
    chk({nm, "_sat"}, d, longint'(ls), longint'(exp_s));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int exp_q[$];
    int t0;
    int lat;
    int r;

    for (int d = 0; d < ND; d++)
      for (int k = 0; k < NT; k++) begin
        coef_m[d][k] = (d == 1) ? 1024 * (k + 1) : (d == 2) ? 8192 : ((k == 0) ? 32767 : 0);
      end
    dec_m[0] = 1; dec_m[1] = 1; dec_m[2] = 1; dec_m[3] = 2;
    model_reset();

    // Reset held with din_vld toggling.
    rst_n = 1'b0;
    for (int i = 0; i < 10; i++) step(1'b0, 1'(i % 2), 100 + i);
    rst_n = 1'b1;
    idle(3);

    // First-output latency measured on the DUT itself.
    step(1'b0, 1'b1, 1234);
    t0 = cyc;
    lat = -1;
    for (int i = 0; i < 40 && lat < 0; i++) begin
      step(1'b0, 1'b0, 0);
      if (o_vld[0] === 1'b1) lat = cyc - t0;
    end
    chk("latency", 0, lat, LAT);
    idle(10);

    // Impulse through the ramp coefficients.
    section_start();
    send(32, 64);
    for (int i = 0; i < 16; i++) send(0, 64);
    exp_q.delete();
    for (int i = 1; i <= 16; i++) exp_q.push_back(i);
    exp_q.push_back(0);
    pin_seq("impulse", 1, exp_q, 1'b0);

    // Rounding with the default impulse coefficient set.
    section_start();
    send(1000, 64);
    send(-3, 64);
    send(-32768, 64);
    exp_q.delete();
    exp_q.push_back(1000); exp_q.push_back(-3); exp_q.push_back(-32767);
    pin_seq("round", 0, exp_q, 1'b0);

    // Saturation on the gain-4 instance.
    section_start();
    for (int i = 0; i < 16; i++) send(32767, 24);
    pin_last("sat_pos", 2, 32767, 1'b1);
    emit_q.delete();
    for (int i = 0; i < 16; i++) send(-32768, 24);
    pin_last("sat_neg", 2, -32768, 1'b1);

    // Overrun: second strobe 5 clocks after the first.
    section_start();
    step(1'b0, 1'b1, 500);
    idle(4);
    step(1'b0, 1'b1, 600);
    idle(40);
    exp_q.delete();
    exp_q.push_back(500);
    pin_seq("overrun", 0, exp_q, 1'b0);
    chk("ovf_model", 0, longint'(ovf_m[0]), 1);
    idle(20);
    step(1'b1, 1'b0, 0);
    idle(2);
    chk("ovf_cleared_model", 0, longint'(ovf_m[0]), 0);

    // Decimate-by-2 phase behaviour.
    section_start();
    send(10, 64); send(20, 64); send(30, 64); send(40, 64);
    exp_q.delete();
    exp_q.push_back(20); exp_q.push_back(40);
    pin_seq("dec2", 3, exp_q, 1'b0);

    section_start();
    send(10, 64);
    step(1'b1, 1'b0, 0);
    idle(5);
    send(20, 64); send(30, 64);
    exp_q.delete();
    exp_q.push_back(30);
    pin_seq("dec2_clr", 3, exp_q, 1'b0);

    section_start();
    send(50, 64);
    step(1'b0, 1'b1, 60);
    idle(4);
    step(1'b1, 1'b0, 0);
    idle(40);
    exp_q.delete();
    pin_seq("dec2_abort", 3, exp_q, 1'b0);

    // Reset in the middle of a MAC sequence.
    section_start();
    step(1'b0, 1'b1, 777);
    idle(5);
    rst_n = 1'b0;
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b1, 5);
    rst_n = 1'b1;
    idle(30);
    exp_q.delete();
    pin_seq("reset_abort", 0, exp_q, 1'b0);

    // Randomised traffic including overruns and clears.
    for (int n = 0; n < 300; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3)       step(1'b1, 1'b1, int'($urandom_range(0, 65535)) - 32768);
      else if (r < 7)  step(1'b1, 1'b0, 0);
      else             step(1'b0, 1'b1, int'($urandom_range(0, 65535)) - 32768);
      idle(int'($urandom_range(0, 70)));
    end
    idle(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
